// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - 3-source nested-priority interrupt controller
// Edge-latched requests, in-service nesting, one frozen offer to the CPU at a time.
module interrupt_controller #(
    parameter logic [31:0] VEC_BASE        = 32'h0000_0800,
    parameter int unsigned VEC_STRIDE_LOG2 = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  int_req,
    input  logic [2:0]  int_mask,
    input  logic        ie,
    input  logic        int_ack,
    input  logic        eret,
    input  logic [2:0]  int_clr,
    output logic        int_pending,
    output logic [1:0]  int_id,
    output logic [31:0] int_vector,
    output logic [2:0]  in_service,
    output logic [2:0]  pend_latch
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_req_d;
    logic [2:0]  r_pend;
    logic [2:0]  r_in_service;
    logic [1:0]  r_int_id;
    logic [31:0] r_int_vector;

    logic [2:0]  w_rise;
    logic [2:0]  w_is_top;
    logic [2:0]  w_allowed;
    logic [2:0]  w_elig;
    logic        w_cand_valid;
    logic [1:0]  w_cand_id;
    logic [31:0] w_cand_vector;
    logic [2:0]  w_cur_onehot;
    logic        w_accept;
    logic        w_withdraw;
    logic        w_load;
    logic [2:0]  w_ack_set;
    logic [2:0]  w_eret_clr;
    logic [2:0]  w_pend_next;
    logic [2:0]  w_is_next;

    assign w_rise = int_req & ~r_req_d;

    // Only sources strictly above the highest in-service level may preempt.
    always_comb begin
        w_is_top  = 3'b000;
        w_allowed = 3'b111;
        if (r_in_service[2]) begin
            w_is_top  = 3'b100;
            w_allowed = 3'b000;
        end else if (r_in_service[1]) begin
            w_is_top  = 3'b010;
            w_allowed = 3'b100;
        end else if (r_in_service[0]) begin
            w_is_top  = 3'b001;
            w_allowed = 3'b110;
        end
    end

    assign w_elig        = r_pend & int_mask & w_allowed;
    assign w_cand_valid  = |w_elig;
    assign w_cand_id     = w_elig[2] ? 2'd2 : (w_elig[1] ? 2'd1 : 2'd0);
    assign w_cand_vector = VEC_BASE + ({30'd0, w_cand_id} << VEC_STRIDE_LOG2);

    assign w_cur_onehot = 3'b001 << r_int_id;
    assign w_accept     = (r_state == OFFER) && int_ack;
    assign w_withdraw   = (r_state == OFFER) && !int_ack &&
                          (!ie || !int_mask[r_int_id] || !r_pend[r_int_id]);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ie && w_cand_valid) begin
                    w_state_next = OFFER;
                    w_load       = 1'b1;
                end
            end
            OFFER: begin
                if (w_accept || w_withdraw) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // eret retires the current level before an ack in the same cycle nests a new one.
    assign w_ack_set   = w_accept ? w_cur_onehot : 3'b000;
    assign w_eret_clr  = eret ? w_is_top : 3'b000;
    assign w_is_next   = (r_in_service & ~w_eret_clr) | w_ack_set;
    assign w_pend_next = (r_pend & ~int_clr & ~w_ack_set) | w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_d      <= 3'b000;
            r_pend       <= 3'b000;
            r_in_service <= 3'b000;
            r_int_id     <= 2'd0;
            r_int_vector <= VEC_BASE;
        end else begin
            r_req_d      <= int_req;
            r_pend       <= w_pend_next;
            r_in_service <= w_is_next;
            if (w_load) begin
                r_int_id     <= w_cand_id;
                r_int_vector <= w_cand_vector;
            end
        end
    end

    assign int_pending = (r_state == OFFER);
    assign int_id      = r_int_id;
    assign int_vector  = r_int_vector;
    assign in_service  = r_in_service;
    assign pend_latch  = r_pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and random checks against a behavioural model
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  int_req = 3'b000;
    logic [2:0]  int_mask = 3'b000;
    logic        ie = 1'b0;
    logic        int_ack = 1'b0;
    logic        eret = 1'b0;
    logic [2:0]  int_clr = 3'b000;
    logic        int_pending;
    logic [1:0]  int_id;
    logic [31:0] int_vector;
    logic [2:0]  in_service;
    logic [2:0]  pend_latch;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    bit m_req_d [3];
    bit m_pend  [3];
    bit m_is    [3];
    bit m_offer;
    int m_id;

    interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .int_req    (int_req),
        .int_mask   (int_mask),
        .ie         (ie),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_clr    (int_clr),
        .int_pending(int_pending),
        .int_id     (int_id),
        .int_vector (int_vector),
        .in_service (in_service),
        .pend_latch (pend_latch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_pend_bits();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [2:0] m_is_bits();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = m_is[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_req_d[i] = 1'b0;
            m_pend[i]  = 1'b0;
            m_is[i]    = 1'b0;
        end
        m_offer = 1'b0;
        m_id    = 0;
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_edge();
        int  top;
        int  cand;
        bit  accept;
        bit  rise [3];
        top = -1;
        for (int i = 0; i < 3; i++) if (m_is[i]) top = i;
        cand = -1;
        for (int i = top + 1; i < 3; i++) if (m_pend[i] && int_mask[i]) cand = i;
        for (int i = 0; i < 3; i++) rise[i] = int_req[i] && !m_req_d[i];
        accept = m_offer && int_ack;
        if (!m_offer) begin
            if (ie && cand >= 0) begin
                m_offer = 1'b1;
                m_id    = cand;
            end
        end else if (int_ack) begin
            m_offer = 1'b0;
        end else if (!ie || !int_mask[m_id] || !m_pend[m_id]) begin
            m_offer = 1'b0;
        end
        if (eret && top >= 0) m_is[top] = 1'b0;
        if (accept) m_is[m_id] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rise[i]) m_pend[i] = 1'b1;
            else if (int_clr[i] || (accept && m_id == i)) m_pend[i] = 1'b0;
            m_req_d[i] = int_req[i];
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_vec;
        exp_vec = 32'h800 + 32'(m_id) * 32'd128;
        chk("pending", {31'd0, int_pending}, {31'd0, m_offer});
        chk("int_id", {30'd0, int_id}, 32'(m_id));
        chk("vector", int_vector, exp_vec);
        chk("in_service", {29'd0, in_service}, {29'd0, m_is_bits()});
        chk("pend_latch", {29'd0, pend_latch}, {29'd0, m_pend_bits()});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        int_ack = 1'b0;
        eret    = 1'b0;
        int_clr = 3'b000;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pending"}, {31'd0, int_pending}, 32'd0);
        chk({tag, "_id"}, {30'd0, int_id}, 32'd0);
        chk({tag, "_vector"}, int_vector, 32'h800);
        chk({tag, "_is"}, {29'd0, in_service}, 32'd0);
        chk({tag, "_pend"}, {29'd0, pend_latch}, 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_values("reset");

        // request already high when reset releases
        int_req  = 3'b010;
        ie       = 1'b1;
        int_mask = 3'b111;
        rst      = 1'b0;
        step();
        chk("release_edge", {29'd0, pend_latch}, 32'b010);
        step();
        chk("offer1_pending", {31'd0, int_pending}, 32'd1);
        chk("offer1_vector", int_vector, 32'h880);
        ie = 1'b0;
        step();
        chk("withdraw_pending", {31'd0, int_pending}, 32'd0);
        chk("withdraw_pend", {29'd0, pend_latch}, 32'b010);
        ie = 1'b1;
        step();
        chk("reoffer_id", {30'd0, int_id}, 32'd1);
        int_ack = 1'b1;
        step();
        eret = 1'b1;
        step();
        int_req = 3'b000;
        step();

        // single source
        int_req = 3'b001;
        step();
        chk("single_pend", {29'd0, pend_latch}, 32'b001);
        int_req = 3'b000;
        step();
        chk("single_vector", int_vector, 32'h800);
        int_ack = 1'b1;
        step();
        chk("single_is", {29'd0, in_service}, 32'b001);
        eret = 1'b1;
        step();
        chk("single_eret", {29'd0, in_service}, 32'b000);

        // priority
        int_req = 3'b101;
        step();
        int_req = 3'b000;
        step();
        chk("prio_id", {30'd0, int_id}, 32'd2);
        chk("prio_vector", int_vector, 32'h900);
        int_ack = 1'b1;
        step();
        step();
        chk("prio_blocked", {31'd0, int_pending}, 32'd0);
        eret = 1'b1;
        step();
        step();
        chk("prio_low_offer", {31'd0, int_pending}, 32'd1);
        chk("prio_low_id", {30'd0, int_id}, 32'd0);
        int_ack = 1'b1;
        step();
        eret = 1'b1;
        step();

        // nesting
        int_req = 3'b001;
        step();
        int_req = 3'b000;
        step();
        int_ack = 1'b1;
        step();
        int_req = 3'b010;
        step();
        int_req = 3'b000;
        step();
        chk("nest_id", {30'd0, int_id}, 32'd1);
        int_ack = 1'b1;
        step();
        chk("nest_is", {29'd0, in_service}, 32'b011);
        eret = 1'b1;
        step();
        chk("nest_eret1", {29'd0, in_service}, 32'b001);
        eret = 1'b1;
        step();
        chk("nest_eret2", {29'd0, in_service}, 32'b000);

        // clear and new edge together: set wins
        ie      = 1'b0;
        int_req = 3'b010;
        int_clr = 3'b010;
        step();
        chk("clr_vs_edge", {29'd0, pend_latch}, 32'b010);
        int_req = 3'b000;
        int_clr = 3'b010;
        step();
        chk("clr_only", {29'd0, pend_latch}, 32'b000);
        ie = 1'b1;

        // eret and ack in the same cycle
        int_req = 3'b001;
        step();
        int_req = 3'b000;
        step();
        int_ack = 1'b1;
        step();
        int_req = 3'b010;
        step();
        int_req = 3'b000;
        step();
        int_ack = 1'b1;
        eret    = 1'b1;
        step();
        chk("eret_ack_is", {29'd0, in_service}, 32'b010);
        eret = 1'b1;
        step();

        // asynchronous reset while offering
        int_req = 3'b100;
        step();
        int_req = 3'b000;
        step();
        chk("pre_reset_offer", {31'd0, int_pending}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) int_req = 3'($urandom_range(0, 7));
            int_mask = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            ie       = ($urandom_range(0, 9) != 0);
            int_ack  = ($urandom_range(0, 2) == 0);
            eret     = ($urandom_range(0, 5) == 0);
            int_clr  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
